// File: rtl/hamming_decoder_pipe.sv
// ---------------------------------------------------------------------------
// hamming_decoder_pipe
//   Two-stage streaming Hamming(7,4) single-error-correcting decoder for the
//   receive side of the link. Stage 1 captures the codeword and its syndrome.
//   Stage 2 flips the indicated bit and extracts the four data bits. Both
//   stages stall under output backpressure. Saturating counters track the
//   words delivered and the words that needed correction.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       in_code holds a codeword
//   in_ready       decoder can take a codeword this cycle (combinational)
//   in_code[6:0]   {d3,d2,d1,p4,d0,p2,p1}
//   out_valid      out_* fields hold a decoded word
//   out_ready      consumer takes the word this cycle
//   out_data[3:0]  corrected data {d3,d2,d1,d0}
//   out_syndrome   raw syndrome {s4,s2,s1}
//   out_corrected  a single bit was flipped to correct the word
//   clr_count      synchronous clear of both counters
//   word_count     words emitted, saturating
//   corr_count     corrected words emitted, saturating
// ---------------------------------------------------------------------------
module hamming_decoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  input  logic             clr_count,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] corr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       v1;
  logic       v2;
  logic [6:0] code1;
  logic [2:0] syn1;
  logic [2:0] syn_in;
  logic [6:0] flip;
  logic [6:0] fixed_code;
  logic       adv1;
  logic       adv2;
  logic       out_xfer;

  // A stage may advance when it is empty or the stage after it is advancing;
  // the only combinational path through the block is out_ready -> in_ready.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  assign out_xfer  = v2 && out_ready;

  // Each syndrome bit checks the codeword positions whose 1-based index has
  // that bit set, so a nonzero syndrome is the position of the flipped bit.
  assign syn_in = {in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6],
                   in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6],
                   in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      code1 <= '0;
      syn1  <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        code1 <= in_code;
        syn1  <= syn_in;
      end
    end
  end

  always_comb begin
    flip = '0;
    if (syn1 != 3'd0) flip[syn1 - 3'd1] = 1'b1;
  end

  assign fixed_code = code1 ^ flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2            <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data      <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
        out_syndrome  <= syn1;
        out_corrected <= (syn1 != 3'd0);
      end
    end
  end

  // Clear takes priority over a same-cycle increment; both counters stick
  // at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      corr_count <= '0;
    end else if (clr_count) begin
      word_count <= '0;
      corr_count <= '0;
    end else if (out_xfer) begin
      if (word_count != CNT_MAX) word_count <= word_count + CNT_ONE;
      if (out_corrected && (corr_count != CNT_MAX)) corr_count <= corr_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_hamming_decoder_pipe
//   Directed bench for hamming_decoder_pipe. dut uses the default counter
//   width; sat_dut shares all inputs but has 2-bit counters so saturation
//   can be reached quickly.
// ---------------------------------------------------------------------------
module tb_hamming_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  in_code;
  logic        out_ready;
  logic        clr_count;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_syndrome;
  logic        out_corrected;
  logic [15:0] word_count;
  logic [15:0] corr_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [3:0]  out_data2;
  logic [2:0]  out_syndrome2;
  logic        out_corrected2;
  logic [1:0]  word_count2;
  logic [1:0]  corr_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_decoder_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .clr_count(clr_count),
    .word_count(word_count), .corr_count(corr_count)
  );

  hamming_decoder_pipe #(.CNT_W(2)) sat_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_syndrome(out_syndrome2),
    .out_corrected(out_corrected2), .clr_count(clr_count),
    .word_count(word_count2), .corr_count(corr_count2)
  );

  // Encoder for the fixed bit layout {d3,d2,d1,p4,d0,p2,p1}.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_count = 1'b0;
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (in_ready2 !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready2 got=%b exp=1", in_ready2); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if ({out_data, out_syndrome, out_corrected} !== 8'h00) begin n_err++;
      $display("[TB] FAIL reset_out_fields got=%h/%h/%b exp=0/0/0", out_data, out_syndrome, out_corrected); end
    n_cmp++; if (word_count !== 16'd0 || corr_count !== 16'd0) begin n_err++;
      $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", word_count, corr_count); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_word();
    in_valid = 1'b1; in_code = 7'h55; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL clean_early_valid got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL clean_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_data !== 4'b1011) begin n_err++; $display("[TB] FAIL clean_data got=%b exp=1011", out_data); end
    n_cmp++; if (out_syndrome !== 3'd0 || out_corrected !== 1'b0) begin n_err++;
      $display("[TB] FAIL clean_syn got=%0d/%b exp=0/0", out_syndrome, out_corrected); end
    tick();
    n_cmp++; if (word_count !== 16'd1 || corr_count !== 16'd0) begin n_err++;
      $display("[TB] FAIL clean_counts got=%0d/%0d exp=1/0", word_count, corr_count); end
  endtask

  task automatic test_single_flips();
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_syndrome !== 3'(i - 1) || out_corrected !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL flip_bit%0d got v=%b d=%b s=%0d c=%b exp v=1 d=1011 s=%0d c=1",
                   i - 2, out_valid, out_data, out_syndrome, out_corrected, i - 1);
        end
      end
      in_valid = (i < 7);
      in_code  = (i < 7) ? (7'h55 ^ (7'd1 << i)) : 7'h00;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (corr_count !== 16'd7 || word_count !== 16'd7) begin n_err++;
      $display("[TB] FAIL flip_counts got=%0d/%0d exp=7/7", word_count, corr_count); end
  endtask

  task automatic test_backpressure();
    logic [6:0] words [4];
    logic [3:0] exp_d [4];
    logic [2:0] exp_s [4];
    int n_in, n_out;
    logic accepted, held;
    words = '{7'h07, 7'h1D, 7'h3F, 7'h4B};
    exp_d = '{4'h1, 4'h2, 4'hF, 4'h8};
    exp_s = '{3'd0, 3'd3, 3'd7, 3'd0};
    n_in = 0; n_out = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_code = words[n_in];
      #1;
      accepted = in_ready;
      if (c >= 2) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready cyc%0d got=%b exp=0", c, in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h1 || out_syndrome !== 3'd0) begin n_err++;
          $display("[TB] FAIL bp_hold cyc%0d got v=%b d=%h s=%0d exp v=1 d=1 s=0", c, out_valid, out_data, out_syndrome); end
      end
      @(posedge clk); #1;
      if (accepted) n_in++;
    end
    n_cmp++; if (n_in !== 2) begin n_err++; $display("[TB] FAIL bp_accepted got=%0d exp=2", n_in); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n_out < 4; c++) begin
      in_valid = (n_in < 4);
      in_code  = (n_in < 4) ? words[n_in] : 7'h00;
      #1;
      accepted = in_valid && in_ready;
      held     = out_valid;
      if (held) begin
        n_cmp++;
        if (out_data !== exp_d[n_out] || out_syndrome !== exp_s[n_out]) begin n_err++;
          $display("[TB] FAIL bp_drain%0d got d=%h s=%0d exp d=%h s=%0d", n_out, out_data, out_syndrome, exp_d[n_out], exp_s[n_out]); end
      end
      @(posedge clk); #1;
      if (accepted) n_in++;
      if (held) n_out++;
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (n_out !== 4 || out_valid !== 1'b0) begin n_err++;
      $display("[TB] FAIL bp_drain_count got=%0d v=%b exp=4 v=0", n_out, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [16];
    logic [2:0] exp_s [16];
    logic [3:0] d;
    int k;
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_d[i-2] || out_syndrome !== exp_s[i-2] ||
            out_corrected !== (exp_s[i-2] != 3'd0)) begin
          n_err++;
          $display("[TB] FAIL b2b_word%0d got v=%b d=%h s=%0d c=%b exp v=1 d=%h s=%0d",
                   i - 2, out_valid, out_data, out_syndrome, out_corrected, exp_d[i-2], exp_s[i-2]);
        end
      end
      if (i < 16) begin
        d = 4'($urandom_range(0, 15));
        k = $urandom_range(0, 7);
        exp_d[i] = d;
        exp_s[i] = (k < 7) ? 3'(k + 1) : 3'd0;
        in_valid = 1'b1;
        in_code  = (k < 7) ? (encode(d) ^ (7'd1 << k)) : encode(d);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    n_cmp++; if (word_count !== 16'd16) begin n_err++; $display("[TB] FAIL b2b_word_count got=%0d exp=16", word_count); end
  endtask

  task automatic test_saturation_clear();
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 5);
      in_code  = 7'h54;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (word_count2 !== 2'd3 || corr_count2 !== 2'd3) begin n_err++;
      $display("[TB] FAIL sat_counts got=%0d/%0d exp=3/3", word_count2, corr_count2); end
    n_cmp++; if (word_count !== 16'd5 || corr_count !== 16'd5) begin n_err++;
      $display("[TB] FAIL sat_wide_counts got=%0d/%0d exp=5/5", word_count, corr_count); end
    in_valid = 1'b1; in_code = 7'h55;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid2 !== 1'b1 || in_ready2 !== 1'b1 || out_data2 !== 4'b1011 ||
                 out_syndrome2 !== 3'd0 || out_corrected2 !== 1'b0) begin n_err++;
      $display("[TB] FAIL sat_word got v=%b r=%b d=%b s=%0d c=%b exp v=1 r=1 d=1011 s=0 c=0",
               out_valid2, in_ready2, out_data2, out_syndrome2, out_corrected2); end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    n_cmp++; if (word_count2 !== 2'd0 || corr_count2 !== 2'd0 || word_count !== 16'd0 || corr_count !== 16'd0) begin n_err++;
      $display("[TB] FAIL clr_wins got=%0d/%0d wide=%0d/%0d exp=0/0 0/0", word_count2, corr_count2, word_count, corr_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL clr_xfer_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 7'h07;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (word_count !== 16'd1) begin n_err++; $display("[TB] FAIL rst_pre_count got=%0d exp=1", word_count); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 7'h19;
    tick();
    in_code = 7'h4B;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++;
      $display("[TB] FAIL rst_pipe_full got v=%b r=%b exp v=1 r=0", out_valid, in_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || word_count !== 16'd0 || corr_count !== 16'd0 || out_data !== 4'h0) begin n_err++;
      $display("[TB] FAIL rst_async got v=%b cnt=%0d/%0d d=%h exp v=0 cnt=0/0 d=0", out_valid, word_count, corr_count, out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_in_ready got=%b exp=1", in_ready); end
    #1;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 7'h19;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_no_stale got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h2 || out_syndrome !== 3'd0) begin n_err++;
      $display("[TB] FAIL rst_resume got v=%b d=%h s=%0d exp v=1 d=2 s=0", out_valid, out_data, out_syndrome); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_word();
    test_single_flips();
    test_backpressure();
    test_back_to_back();
    test_saturation_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
